data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised MEM-stage data memory for the pipeline CPU. Byte-addressed, little-endian.
//  Supports byte/half/word loads and stores, with sign or zero extension on loads.
//  A self-initialising reset FSM fills the array; busy stalls the pipeline meanwhile.
//  Flags misaligned and out-of-range accesses. Sits between the EX/MEM and MEM/WB registers.
// PARAMETERS
//  DEPTH     32  number of 32-bit words; power of 2, >=4
//  ADDR_W    32  byte-address width
//  INIT_MODE 1   0: fill all words with 0; 1: word i = i (zero-extended)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       reset, synchronous, active-high
//  we        in   1       store request
//  re        in   1       load request; used only for error flagging, since the read path is always live
//  size      in   2       00 byte, 01 half, 10 word, 11 reserved
//  uns       in   1       1: zero-extend loads; 0: sign-extend
//  addr      in   ADDR_W  byte address
//  datain    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  dataout   out  32      load data, extended, combinational
//  busy      out  1       init sequence running
//  misalign  out  1       combinational, current access misaligned or size==11
//  oor       out  1       combinational, addr >= 4*DEPTH
//  err       out  1       sticky registered error flag
// BEHAVIOUR
//  Reset
//   - Any posedge with rst=1: state<=INIT, ptr<=0, err<=0.
//   - Reset held: state stays INIT with ptr=0 and busy=1. No array writes happen while rst=1.
//   - Reset asserted mid-INIT restarts from ptr=0.
//  FSM {INIT, RUN}
//   - INIT, rst=0: each posedge writes ram[ptr]<=init(ptr), then ptr<=ptr+1.
//   - When ptr==DEPTH-1 the write completes and state<=RUN.
//   - busy=1 for exactly DEPTH cycles after rst falls. busy=(state==INIT).
//  During busy
//   - User stores are ignored.
//   - dataout=0, misalign=0, oor=0, err unchanged.
//  Index and lanes
//   - word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
//   - oor = |addr[ADDR_W-1:log2(DEPTH)+2].
//  Alignment
//   - misalign = (size==01 & addr[0]) | (size==10 & |addr[1:0]) | (size==11), qualified by (we|re).
//  Store (RUN)
//   - At posedge, if we & ~misalign & ~oor, write only the selected lanes:
//     byte -> lane addr[1:0]; half -> lanes {addr[1],0}+{0,1}; word -> all four lanes.
//   - Unselected lanes keep their old value.
//   - A store that is illegal (misaligned or oor) leaves the array untouched.
//  Load
//   - dataout is combinational from the array word.
//   - byte: 8 bits at lane; half: 16 bits at addr[1]; word: all 32 bits.
//   - Then zero- or sign-extend to 32 per uns.
//   - oor or misalign forces dataout=0.
//  Same-cycle store and load to one address: dataout shows the old data until the edge,
//  and the new data after it (asynchronous read, no bypass).
//  err: at posedge in RUN, err<=err | ((we|re) & (misalign|oor)). Cleared only by rst.
// STRUCTURE
//  Package dmem_pkg
//   - SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
//   - FSM state encoding ST_INIT, ST_RUN
//   - function init_word(idx, INIT_MODE)
//  Sub-module dmem_load_align
//   - Combinational lane select and extension: inputs word, lane, size, uns; output 32-bit dataout.
//  Top level holds the array, the FSM and ptr, store lane-enable generation, and error logic.
// TESTING
//  1 Init: rst 3 cycles, DEPTH=32, INIT_MODE=1 -> busy high 32 cycles, then low;
//    load word @0x14 -> 0x00000005.
//  2 Byte store/load: sw 0x00000000 @0x20; sb datain=0x000000F0 @0x22;
//    lb @0x22 uns=0 -> 0xFFFFFFF0; lbu -> 0x000000F0; lw @0x20 -> 0x00F00000.
//  3 Half store: sh 0x00008001 @0x12 over word 0x00000004 ->
//    lw @0x10 = 0x80010004; lh @0x12 = 0xFFFF8001.
//  4 Misaligned: sw 0xDEADBEEF @0x06 -> misalign=1, word @0x04 still 1, err=1 next cycle.
//    Then oor lw @0x80 -> dataout=0, oor=1.
//  5 Busy blocking: store 0xAAAAAAAA @0x00 on cycle 2 of INIT -> ignored; word @0x00 reads 0 after init.
//  6 Reset mid-INIT: rst pulsed at ptr=10 -> busy stays 32 further cycles;
//    err cleared; all words re-initialised.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM states and init helper for the data memory
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Power-up contents: all zero, or each word holding its own index.
   function automatic logic [31:0] init_word(input int idx, input int mode);
      return (mode == 0) ? 32'd0 : 32'(idx);
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the loaded byte/half/word lane and extends it to 32 bits
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] dataout
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      dataout = 32'd0;
      case (size)
         SZ_B:    dataout = {{24{~uns & byte_sel[7]}}, byte_sel};
         SZ_H:    dataout = {{16{~uns & half_sel[15]}}, half_sel};
         SZ_W:    dataout = word;
         default: dataout = 32'd0;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage byte-addressed data memory with self-initialising reset FSM
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int ADDR_W    = 32,
   parameter int INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       datain,
   output logic [31:0]       dataout,
   output logic              busy,
   output logic              misalign,
   output logic              oor,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  ptr;
   logic [31:0]       ram [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic              access;
   logic              mis_raw;
   logic              st_ok;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rd_word;
   logic [31:0]       load_data;

   assign idx    = addr[IDX_W+1:2];
   assign lane   = addr[1:0];
   assign access = we | re;
   assign busy   = (state == ST_INIT);

   always_comb begin
      mis_raw = 1'b0;
      case (size)
         SZ_B:    mis_raw = 1'b0;
         SZ_H:    mis_raw = addr[0];
         SZ_W:    mis_raw = |addr[1:0];
         default: mis_raw = 1'b1;
      endcase
   end

   // Flags stay quiet while the array is still being initialised.
   assign misalign = ~busy & access & mis_raw;
   assign oor      = ~busy & (|addr[ADDR_W-1:IDX_W+2]);
   assign st_ok    = ~busy & we & ~misalign & ~oor;

   // Store data is replicated across lanes; the byte enables pick which lanes land.
   always_comb begin
      be    = 4'b0000;
      wdata = datain;
      case (size)
         SZ_B: begin
            be    = 4'b0001 << lane;
            wdata = {4{datain[7:0]}};
         end
         SZ_H: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{datain[15:0]}};
         end
         SZ_W: begin
            be    = 4'b1111;
            wdata = datain;
         end
         default: begin
            be    = 4'b0000;
            wdata = datain;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_INIT && ptr == LAST)
         state_nxt = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         ptr   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (busy)
            ptr <= ptr + 1'b1;
         else
            err <= err | (access & (misalign | oor));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy) begin
            ram[ptr] <= init_word(int'(ptr), INIT_MODE);
         end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i])
                  ram[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Asynchronous read: a same-cycle store only becomes visible after the edge.
   assign rd_word = ram[idx];

   dmem_load_align u_align (
      .word    (rd_word),
      .lane    (lane),
      .size    (size),
      .uns     (uns),
      .dataout (load_data)
   );

   assign dataout = (busy | misalign | oor) ? 32'd0 : load_data;

endmodule
